led_bank: RTL and testbench

LED_BANK -- requirements
Module: led_bank

---
 rtl/led_bank.sv | 146 ++++++++++++++
 tb/tb_led_bank.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_bank.sv
// led_bank: bus-mapped LED bank with per-bit blink mask, global PWM dimming
// Ports: CLK, RESET (async, active-low), BUS_ADDR/BUS_DATA_IN/BUS_WE in, BUS_DATA_OUT/BUS_DATA_OE out, LEDS out
module led_bank #(
  parameter logic [7:0] BASE_ADDR = 8'hC0,
  parameter int NUM_BYTES = 2,
  parameter int PRESCALE  = 50000
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [7:0]             BUS_ADDR,
  input  logic [7:0]             BUS_DATA_IN,
  input  logic                   BUS_WE,
  output logic [7:0]             BUS_DATA_OUT,
  output logic                   BUS_DATA_OE,
  output logic [8*NUM_BYTES-1:0] LEDS
);

  localparam int N  = NUM_BYTES;
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [7:0] O_DUTY = 8'(2 * N);
  localparam logic [7:0] O_CTRL = 8'(2 * N + 1);
  localparam logic [7:0] O_RATE = 8'(2 * N + 2);

  logic [N-1:0][7:0] data_q;
  logic [N-1:0][7:0] bmask_q;
  logic [7:0]        duty_q;
  logic [7:0]        rate_q;
  logic [7:0]        blink_q;
  logic [7:0]        pwm_q;
  logic              en_q;
  logic              pwm_en_q;
  logic              phase_q;
  logic [PW-1:0]     pre_q;

  logic [7:0]   off;
  logic [N-1:0] data_sel;
  logic [N-1:0] bmask_sel;
  logic         duty_sel;
  logic         ctrl_sel;
  logic         rate_sel;
  logic         mapped;
  logic [7:0]   rd_val;
  logic         tick;
  logic         pwm_on;
  logic [8*N-1:0] leds_nxt;

  // Offset wraps, so addresses below the base land far above the window.
  assign off = BUS_ADDR - BASE_ADDR;

  always_comb begin
    data_sel  = '0;
    bmask_sel = '0;
    rd_val    = '0;
    duty_sel  = (off == O_DUTY);
    ctrl_sel  = (off == O_CTRL);
    rate_sel  = (off == O_RATE);
    for (int k = 0; k < N; k++) begin
      data_sel[k]  = (off == 8'(k));
      bmask_sel[k] = (off == 8'(N + k));
      if (data_sel[k])  rd_val = data_q[k];
      if (bmask_sel[k]) rd_val = bmask_q[k];
    end
    unique case (1'b1)
      duty_sel: rd_val = duty_q;
      ctrl_sel: rd_val = {6'b0, pwm_en_q, en_q};
      rate_sel: rd_val = rate_q;
      default:  ;
    endcase
    mapped = (|data_sel) | (|bmask_sel)
           | duty_sel | ctrl_sel | rate_sel;
  end

  assign tick   = (pre_q == PRE_MAX);
  assign pwm_on = ~pwm_en_q | (pwm_q < duty_q);

  // Masked bits follow the blink phase; unmasked bits stay lit.
  assign leds_nxt = {(8*N){en_q & pwm_on}}
                  & data_q
                  & ({(8*N){phase_q}} | ~bmask_q);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int k = 0; k < N; k++) begin
        data_q[k]  <= (k == 0) ? 8'hF0 : 8'h00;
        bmask_q[k] <= 8'h00;
      end
      duty_q   <= 8'hFF;
      en_q     <= 1'b1;
      pwm_en_q <= 1'b0;
    end else if (BUS_WE) begin
      for (int k = 0; k < N; k++) begin
        if (data_sel[k])  data_q[k]  <= BUS_DATA_IN;
        if (bmask_sel[k]) bmask_q[k] <= BUS_DATA_IN;
      end
      if (duty_sel) duty_q <= BUS_DATA_IN;
      if (ctrl_sel) begin
        en_q     <= BUS_DATA_IN[0];
        pwm_en_q <= BUS_DATA_IN[1];
      end
    end
  end

  // A RATE write restarts the blink period from a lit phase.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rate_q  <= 8'h0F;
      pre_q   <= '0;
      blink_q <= '0;
      phase_q <= 1'b1;
    end else if (BUS_WE && rate_sel) begin
      rate_q  <= BUS_DATA_IN;
      pre_q   <= '0;
      blink_q <= '0;
      phase_q <= 1'b1;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        if (blink_q == rate_q) begin
          blink_q <= '0;
          phase_q <= ~phase_q;
        end else begin
          blink_q <= blink_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pwm_q        <= '0;
      LEDS         <= '0;
      BUS_DATA_OUT <= '0;
      BUS_DATA_OE  <= 1'b0;
    end else begin
      pwm_q       <= pwm_q + 8'd1;
      LEDS        <= leds_nxt;
      BUS_DATA_OE <= 1'b0;
      if (!BUS_WE && mapped) begin
        BUS_DATA_OUT <= rd_val;
        BUS_DATA_OE  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_bank.sv
// tb_led_bank: randomized bench for led_bank against a behavioural model
// Drives the bus on negedge, compares LEDS/BUS_DATA_* on every negedge
module tb_led_bank;

  localparam int N = 2;
  localparam int P = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [7:0]  BUS_ADDR = 8'h00;
  logic [7:0]  BUS_DATA_IN = 8'h00;
  logic        BUS_WE = 1'b0;
  logic [7:0]  BUS_DATA_OUT;
  logic        BUS_DATA_OE;
  logic [15:0] LEDS;

  always #5 CLK = ~CLK;

  led_bank #(
    .BASE_ADDR(8'hC0),
    .NUM_BYTES(N),
    .PRESCALE(P)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .BUS_ADDR(BUS_ADDR),
    .BUS_DATA_IN(BUS_DATA_IN),
    .BUS_WE(BUS_WE),
    .BUS_DATA_OUT(BUS_DATA_OUT),
    .BUS_DATA_OE(BUS_DATA_OE),
    .LEDS(LEDS)
  );

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, got, exp, $time);
    end
  endtask

  // Behavioural model: phase and PWM derived from elapsed edge counts.
  logic [7:0]  m_data [N];
  logic [7:0]  m_bmask [N];
  logic [7:0]  m_duty;
  logic [7:0]  m_rate;
  logic [7:0]  m_dout;
  logic [15:0] m_leds;
  bit          m_en;
  bit          m_pwmen;
  bit          m_oe;
  int          m_epoch;
  int          m_edges;

  task automatic m_reset();
    m_data[0] = 8'hF0;
    m_data[1] = 8'h00;
    m_bmask[0] = 8'h00;
    m_bmask[1] = 8'h00;
    m_duty = 8'hFF;
    m_rate = 8'h0F;
    m_en = 1'b1;
    m_pwmen = 1'b0;
    m_dout = 8'h00;
    m_oe = 1'b0;
    m_leds = 16'h0000;
    m_epoch = 0;
    m_edges = 0;
  endtask

  function automatic logic [7:0] m_read(input int o);
    if (o < N) return m_data[o];
    if (o < 2 * N) return m_bmask[o - N];
    if (o == 2 * N) return m_duty;
    if (o == 2 * N + 1) return {6'b0, m_pwmen, m_en};
    return m_rate;
  endfunction

  task automatic m_step();
    logic [7:0] off8;
    int o;
    int halves;
    bit phase;
    bit pon;
    off8 = BUS_ADDR - 8'hC0;
    o = int'(off8);
    halves = (m_epoch / P) / (int'(m_rate) + 1);
    phase = (halves % 2) == 0;
    pon = !m_pwmen || ((m_edges % 256) < int'(m_duty));
    for (int i = 0; i < 16; i++)
      m_leds[i] = m_en && pon && m_data[i / 8][i % 8]
               && (phase || !m_bmask[i / 8][i % 8]);
    m_oe = 1'b0;
    if (!BUS_WE && o < 2 * N + 3) begin
      m_oe = 1'b1;
      m_dout = m_read(o);
    end
    if (BUS_WE) begin
      if (o < N) m_data[o] = BUS_DATA_IN;
      else if (o < 2 * N) m_bmask[o - N] = BUS_DATA_IN;
      else if (o == 2 * N) m_duty = BUS_DATA_IN;
      else if (o == 2 * N + 1) begin
        m_en = BUS_DATA_IN[0];
        m_pwmen = BUS_DATA_IN[1];
      end else if (o == 2 * N + 2) begin
        m_rate = BUS_DATA_IN;
        m_epoch = -1;
      end
    end
    m_epoch++;
    m_edges++;
  endtask

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) m_reset();
    else m_step();
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("leds", 32'(LEDS), 32'(m_leds));
      check("oe", 32'(BUS_DATA_OE), 32'(m_oe));
      check("dout", 32'(BUS_DATA_OUT), 32'(m_dout));
    end
  end

  task automatic bus(input logic [7:0] a,
                     input logic w,
                     input logic [7:0] d);
    BUS_ADDR = a;
    BUS_WE = w;
    BUS_DATA_IN = d;
    @(negedge CLK);
    BUS_ADDR = 8'h00;
    BUS_WE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  logic [7:0] exp_ret [7];
  logic [7:0] exp_rst [7];

  initial begin
    int hi;
    int bad;
    int to;
    int r;
    logic [7:0] a;
    logic [7:0] d;
    m_reset();
    exp_ret = '{8'hF0, 8'hFF, 8'h00, 8'hFF,
                8'hFF, 8'h03, 8'h00};
    exp_rst = '{8'hF0, 8'h00, 8'h00, 8'h00,
                8'hFF, 8'h01, 8'h0F};
    idle(2);
    chk_en = 1'b1;
    check("rst_leds", 32'(LEDS), 32'h0);
    check("rst_oe", 32'(BUS_DATA_OE), 32'h0);
    RESET = 1'b1;
    idle(2);
    check("idle_leds", 32'(LEDS), 32'h00F0);
    check("idle_oe", 32'(BUS_DATA_OE), 32'h0);

    bus(8'hC1, 1'b1, 8'hA5);
    bus(8'hC1, 1'b0, 8'h00);
    check("wr_leds", 32'(LEDS), 32'hA5F0);
    check("rd_c1", 32'(BUS_DATA_OUT), 32'hA5);
    check("rd_c1_oe", 32'(BUS_DATA_OE), 32'h1);
    bus(8'hC5, 1'b0, 8'h00);
    check("rd_c5", 32'(BUS_DATA_OUT), 32'h01);
    check("rd_c5_oe", 32'(BUS_DATA_OE), 32'h1);
    idle(1);
    check("oe_pulse", 32'(BUS_DATA_OE), 32'h0);

    bus(8'hC3, 1'b1, 8'hFF);
    bus(8'hC6, 1'b1, 8'h00);
    bus(8'hC1, 1'b1, 8'hFF);
    idle(3);
    hi = 0;
    bad = 0;
    repeat (64) begin
      @(negedge CLK);
      if (LEDS[15:8] == 8'hFF) hi++;
      if (LEDS[7:0] != 8'hF0) bad++;
    end
    check("blink_on", 32'(hi), 32'd32);
    check("blink_steady", 32'(bad), 32'd0);

    bus(8'hC5, 1'b1, 8'h03);
    bus(8'hC4, 1'b1, 8'h40);
    idle(2);
    hi = 0;
    repeat (256) begin
      @(negedge CLK);
      if (LEDS[4]) hi++;
    end
    check("pwm_on", 32'(hi), 32'd64);
    bus(8'hC4, 1'b1, 8'h00);
    idle(1);
    check("duty0", 32'(LEDS), 32'h0);

    bus(8'hC4, 1'b1, 8'hFF);
    bus(8'hBF, 1'b1, 8'h12);
    bus(8'hC7, 1'b1, 8'h34);
    bus(8'hC7, 1'b0, 8'h00);
    check("unmap_oe", 32'(BUS_DATA_OE), 32'h0);
    for (int i = 0; i < 7; i++) begin
      bus(8'hC0 + 8'(i), 1'b0, 8'h00);
      check($sformatf("regs_%0d", i),
            32'(BUS_DATA_OUT), 32'(exp_ret[i]));
    end

    bus(8'hC5, 1'b1, 8'h01);
    to = 0;
    while (LEDS[15:8] != 8'h00 && to < 40) begin
      @(negedge CLK);
      to++;
    end
    check("phase0_wait", 32'(to < 40), 32'h1);
    #1 RESET = 1'b0;
    #1;
    check("async_leds", 32'(LEDS), 32'h0);
    check("async_oe", 32'(BUS_DATA_OE), 32'h0);
    check("async_dout", 32'(BUS_DATA_OUT), 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    idle(1);
    check("rel_leds", 32'(LEDS), 32'h00F0);
    for (int i = 0; i < 7; i++) begin
      bus(8'hC0 + 8'(i), 1'b0, 8'h00);
      check($sformatf("rst_reg_%0d", i),
            32'(BUS_DATA_OUT), 32'(exp_rst[i]));
    end

    repeat (3000) begin
      r = int'($urandom_range(0, 99));
      a = 8'hBE + 8'($urandom_range(0, 12));
      d = 8'($urandom);
      if (a == 8'hC6) d = d & 8'h03;
      if (r < 1) begin
        #1 RESET = 1'b0;
        #2 RESET = 1'b1;
        @(negedge CLK);
      end else if (r < 30) begin
        bus(a, 1'b1, d);
      end else if (r < 60) begin
        bus(a, 1'b0, 8'h00);
      end else begin
        idle(1);
      end
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
